// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code output and a wrap pulse.
// The binary count, its Gray code and the wrap flag are all loaded from the
// same next-state value on the same edge, so the outputs always agree with
// each other. Enabled steps change exactly one Gray bit. A load can change
// any number of bits.

module bin_to_gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] g_next;
   logic             wrap_next;

   // Next-state selection: load overrides stepping, and a load never wraps.
   always_comb begin
      b_next    = bin;
      wrap_next = 1'b0;
      if (load) begin
         b_next = load_bin;
      end else if (en) begin
         if (up) begin
            b_next    = bin + ONE;
            wrap_next = (bin == ALL_ONE);
         end else begin
            b_next    = bin - ONE;
            wrap_next = (bin == ZERO);
         end
      end
   end

   // Encode the next count so that gray is registered alongside bin. The MSB passes through unchanged.
   always_comb begin
      g_next = b_next ^ (b_next >> 1);
   end

   // Output registers. A synchronous reset takes priority over load and en.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin  <= ZERO;
         gray <= ZERO;
         wrap <= 1'b0;
      end else begin
         bin  <= b_next;
         gray <= g_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Bench for bin_to_gray_counter. It runs directed vectors on a 4-bit instance,
// checks wrap spacing while free-running, and runs a random model check on a
// 4-bit and an 8-bit instance at the same time.

module tb_bin_to_gray_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, load4, en4, up4;
   logic [3:0] lb4;
   logic [3:0] bin4, gray4;
   logic       wrap4;

   logic       rst8, load8, en8, up8;
   logic [7:0] lb8;
   logic [7:0] bin8, gray8;
   logic       wrap8;

   bin_to_gray_counter #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .load(load4), .load_bin(lb4), .en(en4), .up(up4),
      .bin(bin4), .gray(gray4), .wrap(wrap4)
   );

   bin_to_gray_counter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .load(load8), .load_bin(lb8), .en(en8), .up(up8),
      .bin(bin8), .gray(gray8), .wrap(wrap8)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Decode Gray to binary with a running XOR from the MSB down.
   function automatic int g2b(input logic [15:0] g, input int w);
      int b   = 0;
      bit acc = 1'b0;
      for (int i = w - 1; i >= 0; i--) begin
         acc = acc ^ g[i];
         if (acc) b = b + (1 << i);
      end
      return b;
   endfunction

   typedef struct {
      string      name;
      logic       rst;
      logic       load;
      logic [3:0] lb;
      logic       en;
      logic       up;
      int         e_bin;
      int         e_gray;
      int         e_wrap;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic r, logic l, logic [3:0] lb, logic e, logic u,
                               int eb, int eg, int ew);
      vec_t v;
      v.name = n; v.rst = r; v.load = l; v.lb = lb; v.en = e; v.up = u;
      v.e_bin = eb; v.e_gray = eg; v.e_wrap = ew;
      return v;
   endfunction

   // Gray codes of counts 1..15 and then 0, in order.
   int gray_up[16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                       4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst4 = 1'b1; load4 = 1'b0; lb4 = '0; en4 = 1'b0; up4 = 1'b0;
      rst8 = 1'b1; load8 = 1'b0; lb8 = '0; en8 = 1'b0; up8 = 1'b0;

      // Reset, then count up through one full wrap.
      vecs.push_back(mk("reset_a", 1, 0, 4'h0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("reset_b", 1, 1, 4'h7, 1, 1, 0, 0, 0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk($sformatf("up_%0d", i + 1), 0, 0, 4'h0, 1, 1,
                           (i + 1) % 16, gray_up[i], (i == 15) ? 1 : 0));
      // Count down from reset.
      vecs.push_back(mk("down_reset", 1, 0, 4'h0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("down_wrap", 0, 0, 4'h0, 1, 0, 15, 4'b1000, 1));
      vecs.push_back(mk("down_next", 0, 0, 4'h0, 1, 0, 14, 4'b1001, 0));
      // Load encode. A load with en=1 does no stepping and no wrap.
      vecs.push_back(mk("load_1010", 0, 1, 4'b1010, 0, 0, 10, 4'b1111, 0));
      vecs.push_back(mk("load_en_1111", 0, 1, 4'b1111, 1, 1, 15, 4'b1000, 0));
      vecs.push_back(mk("load_en_0000_dn", 0, 1, 4'b0000, 1, 0, 0, 0, 0));
      // Reverse direction, then hold.
      vecs.push_back(mk("load_0101", 0, 1, 4'b0101, 0, 0, 5, 4'b0111, 0));
      vecs.push_back(mk("rev_up", 0, 0, 4'h0, 1, 1, 6, 4'b0101, 0));
      vecs.push_back(mk("rev_down", 0, 0, 4'h0, 1, 0, 5, 4'b0111, 0));
      vecs.push_back(mk("hold_1", 0, 0, 4'h0, 0, 1, 5, 4'b0111, 0));
      vecs.push_back(mk("hold_2", 0, 0, 4'h0, 0, 0, 5, 4'b0111, 0));
      vecs.push_back(mk("hold_3", 0, 0, 4'h0, 0, 1, 5, 4'b0111, 0));
      // Reset has priority over load and en.
      vecs.push_back(mk("load_1100", 0, 1, 4'b1100, 0, 0, 12, 4'b1010, 0));
      vecs.push_back(mk("rst_prio", 1, 1, 4'b0011, 1, 1, 0, 0, 0));
      vecs.push_back(mk("after_rst_up", 0, 0, 4'h0, 1, 1, 1, 4'b0001, 0));

      foreach (vecs[k]) begin
         rst4 = vecs[k].rst; load4 = vecs[k].load; lb4 = vecs[k].lb;
         en4 = vecs[k].en; up4 = vecs[k].up;
         tick();
         chk({vecs[k].name, ".bin"},  int'(bin4),  vecs[k].e_bin);
         chk({vecs[k].name, ".gray"}, int'(gray4), vecs[k].e_gray);
         chk({vecs[k].name, ".wrap"}, int'(wrap4), vecs[k].e_wrap);
      end

      // Free-running count: wrap pulses once every 16 steps, and only then.
      begin
         int wraps = 0;
         rst4 = 1'b1; load4 = 1'b0; en4 = 1'b0; up4 = 1'b1;
         tick();
         rst4 = 1'b0; en4 = 1'b1;
         for (int s = 1; s <= 40; s++) begin
            tick();
            chk($sformatf("freerun_wrap_%0d", s), int'(wrap4), (s % 16 == 0) ? 1 : 0);
            if (wrap4) wraps++;
         end
         chk("freerun_wrap_count", wraps, 2);
         chk("freerun_bin", int'(bin4), 40 % 16);
      end

      // The 8-bit instance wraps down from zero.
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0; en8 = 1'b1; up8 = 1'b0;
      tick();
      chk("w8_down.bin", int'(bin8), 255);
      chk("w8_down.wrap", int'(wrap8), 1);
      chk("w8_down.gray", int'(gray8), 8'b1000_0000);

      // Random check of both widths against a counting model.
      begin
         int         m4, m8;
         logic [3:0] pg4;
         logic [7:0] pg8;
         bit         r4, l4, e4, u4, r8, l8, e8, u8;
         int         w4, w8;
         int         lv4, lv8;
         rst4 = 1'b1; rst8 = 1'b1; load4 = 1'b0; load8 = 1'b0; en4 = 1'b0; en8 = 1'b0;
         tick();
         m4 = 0; m8 = 0; pg4 = gray4; pg8 = gray8;
         for (int c = 0; c < 10000; c++) begin
            r4 = ($urandom_range(0, 199) == 0);
            l4 = ($urandom_range(0, 15) == 0);
            e4 = ($urandom_range(0, 3) != 0);
            u4 = $urandom_range(0, 1);
            lv4 = $urandom_range(0, 15);
            r8 = ($urandom_range(0, 199) == 0);
            l8 = ($urandom_range(0, 15) == 0);
            e8 = ($urandom_range(0, 3) != 0);
            u8 = $urandom_range(0, 1);
            lv8 = $urandom_range(0, 255);
            rst4 = r4; load4 = l4; en4 = e4; up4 = u4; lb4 = 4'(lv4);
            rst8 = r8; load8 = l8; en8 = e8; up8 = u8; lb8 = 8'(lv8);

            w4 = 0;
            if (r4) m4 = 0;
            else if (l4) m4 = lv4;
            else if (e4 && u4) begin w4 = (m4 == 15); m4 = (m4 + 1) % 16; end
            else if (e4) begin w4 = (m4 == 0); m4 = (m4 + 15) % 16; end
            w8 = 0;
            if (r8) m8 = 0;
            else if (l8) m8 = lv8;
            else if (e8 && u8) begin w8 = (m8 == 255); m8 = (m8 + 1) % 256; end
            else if (e8) begin w8 = (m8 == 0); m8 = (m8 + 255) % 256; end

            tick();
            chk("rnd4.bin", int'(bin4), m4);
            chk("rnd4.g2b", g2b({12'h0, gray4}, 4), m4);
            chk("rnd4.wrap", int'(wrap4), w4);
            if (!r4 && !l4)
               chk("rnd4.hamming", $countones(gray4 ^ pg4), e4 ? 1 : 0);
            chk("rnd8.bin", int'(bin8), m8);
            chk("rnd8.g2b", g2b({8'h0, gray8}, 8), m8);
            chk("rnd8.wrap", int'(wrap8), w8);
            if (!r8 && !l8)
               chk("rnd8.hamming", $countones(gray8 ^ pg8), e8 ? 1 : 0);
            pg4 = gray4;
            pg8 = gray8;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bin_to_gray_counter.md
# bin_to_gray_counter

Registered binary-to-Gray encoder built around a WIDTH-bit up/down counter. It produces the Gray-coded count that the gray_to_bin decoder consumes, so consecutive enabled steps change exactly one output bit. Typical uses are a clock-domain-crossing pointer or a rotary/position code source. A parallel load port encodes an arbitrary binary value into Gray in one cycle.

## Interface
- WIDTH, 4: counter and code width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load load_bin on this edge; overrides en.
- load_bin  input  WIDTH  binary value to load and encode.
- en  input  1  advance the count one step on this edge.
- up  input  1  direction when en=1: 1 = increment, 0 = decrement.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin: bin ^ (bin >> 1).
- wrap  output  1  one-cycle pulse on the step that wraps max→0 (up) or 0→max (down).

## Operation
- Internal state is the binary count b. Both gray and wrap are registered from next-state logic, never decoded combinationally from b.
- Next-state logic for b_next:
  - b_next = load_bin if load=1
  - b_next = b + 1 mod 2^WIDTH if en=1 and up=1
  - b_next = b − 1 mod 2^WIDTH if en=1 and up=0
  - b_next = b otherwise
- Output registers:
  - gray ← b_next ^ (b_next >> 1), with the MSB passed through unchanged.
  - bin ← b_next.
- wrap ← 1 only when load=0, en=1, and one of:
  - up=1 and b = 2^WIDTH−1
  - up=0 and b = 0

  Otherwise wrap ← 0.
- Priority: rst > load > en.
- load with en=1 performs the load only and asserts no wrap, even if load_bin equals the wrap target.
- Arithmetic is unsigned and modulo 2^WIDTH. No saturation.
- up is ignored when en=0. Changing up between steps is legal: the next step reverses direction and the Gray code still changes by exactly one bit.
- Single-bit-change property: every enabled, non-load step changes exactly one bit of gray. A load may change any number of bits.

## Timing
- Reset: on a clk edge with rst=1, bin=0, gray=0 and wrap=0 on the following cycle, regardless of load and en.
- Reset mid-count discards the count. The first enabled step after rst deasserts gives bin=1 (up) or bin=2^WIDTH−1 (down).
- Latency: inputs are sampled on edge N. bin, gray and wrap reflect that sample after edge N and hold until edge N+1.
- wrap is high for exactly one cycle per wrapping step. With en held high across repeated wraps, wrap pulses once every 2^WIDTH cycles.
- No handshake and no backpressure. en may be held high for free-running counting.
- gray and bin come from the same edge and are always mutually consistent; gray_to_bin(gray) == bin in every cycle.

## Test plan
- Reset then count up: rst=1 for 2 cycles, then en=1, up=1 for 16 cycles.
  - gray sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
  - wrap=1 only in the cycle where bin becomes 0.
- Count down from reset: en=1, up=0 for 1 cycle → bin=1111, gray=1000, wrap=1. One more step → bin=1110, gray=1001, wrap=0.
- Load encode: load=1, load_bin=1010 → bin=1010, gray=1111, wrap=0 next cycle. Repeat with load=1, en=1, up=1, load_bin=1111 → bin=1111, gray=1000, no wrap.
- Direction reversal and hold:
  - From bin=0101 (gray 0111), step up → gray 0101.
  - Then step down → gray 0111.
  - Then en=0 for 3 cycles → outputs unchanged.
  - Each step flips exactly one gray bit.
- Reset priority mid-operation: bin=1100, drive rst=1, load=1, load_bin=0011, en=1 on the same edge → bin=0000, gray=0000, wrap=0.
- Randomized property check, WIDTH=4 and WIDTH=8, 10k cycles with random load/en/up:
  - A reference model's gray_to_bin(gray) equals bin every cycle.
  - The Hamming distance between consecutive gray values is 1 on every non-load enabled step and 0 when idle.
